// File: rtl/whack_pkg.sv
// Shared types and constants for the whack-a-mole game controller.
package whack_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_PLAY = 2'd1,
    ST_OVER = 2'd2
  } state_e;

  localparam int unsigned SCORE_W = 8;
  localparam int unsigned SECS_W  = 7;

  localparam logic [15:0] LFSR_SEED = 16'hACE1;
  // Right-shifting Fibonacci form of taps 16,14,13,11: feedback is the XOR of bits 0,2,3,5.
  localparam logic [15:0] LFSR_FB_MASK = 16'h002D;

  function automatic logic [15:0] lfsr_step(input logic [15:0] s);
    return {^(s & LFSR_FB_MASK), s[15:1]};
  endfunction

endpackage

// File: rtl/whack_tick_gen.sv
// Game-second prescaler. tick_o is registered and is high during the cycle in
// which the count sits at TICK_DIV-1, i.e. the cycle whose closing edge wraps it.
module whack_tick_gen import whack_pkg::*; #(
  parameter int unsigned TICK_DIV = 100_000_000
) (
  input  logic clk_i,
  input  logic reset_i,
  input  logic clr_i,   // restart counting from zero on this edge
  input  logic en_i,    // counter runs during the coming cycle
  output logic tick_o
);

  localparam int unsigned CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          tick_q, tick_d;

  // Next count; tick is precomputed from the next count so the output is a flop.
  always_comb begin
    cnt_d = '0;
    if (en_i && !clr_i) begin
      cnt_d = (cnt_q == LAST) ? '0 : cnt_q + CW'(1);
    end
    tick_d = en_i && (cnt_d == LAST);
  end

  // Counter and tick registers.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      cnt_q  <= '0;
      tick_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      tick_q <= tick_d;
    end
  end

  assign tick_o = tick_q;

endmodule

// File: rtl/whack_game_ctrl.sv
// Whack-a-mole round sequencer: FSM, LFSR mole placement, mole lifetime, scoring.
// Optional feature macro: WHACK_BEST_SCORE_EN adds the best_o high-score register.
module whack_game_ctrl import whack_pkg::*; #(
  parameter int unsigned TICK_DIV  = 100_000_000,
  parameter int unsigned GAME_SECS = 30,
  parameter int unsigned N_HOLES   = 8,
  parameter int unsigned MOLE_CYC  = 75_000_000
) (
  input  logic               clk_i,
  input  logic               reset_i,
  input  logic               start_i,
  input  logic [N_HOLES-1:0] hit_i,
  output logic [N_HOLES-1:0] mole_o,
  output logic [6:0]         secs_o,
  output logic [7:0]         score_o,
  output logic [1:0]         state_o,
`ifdef WHACK_BEST_SCORE_EN
  output logic [7:0]         best_o,
`endif
  output logic               sec_tick_o
);

  localparam int unsigned IDX_W = $clog2(N_HOLES);
  localparam int unsigned MT_W  = (MOLE_CYC > 1) ? $clog2(MOLE_CYC) : 1;
  localparam logic [MT_W-1:0]   MT_LAST   = MT_W'(MOLE_CYC - 1);
  localparam logic [SECS_W-1:0] SECS_INIT = SECS_W'(GAME_SECS);

  state_e               state_q, state_d;
  logic [15:0]          lfsr_q;
  logic [N_HOLES-1:0]   mole_q, mole_d;
  logic [SECS_W-1:0]    secs_q, secs_d;
  logic [SCORE_W-1:0]   score_q, score_d;
  logic [MT_W-1:0]      mtmr_q, mtmr_d;
  logic                 tick;
  logic                 enter_play;
  logic                 hit_ok;
  logic [IDX_W-1:0]     idx;
  logic [N_HOLES-1:0]   place, reloc;

  assign idx = lfsr_q[IDX_W-1:0];

  // Candidate mole position; rotating the one-hot left gives (idx+1) mod N_HOLES.
  always_comb begin
    place      = '0;
    place[idx] = 1'b1;
    reloc      = (place == mole_q) ? {place[N_HOLES-2:0], place[N_HOLES-1]} : place;
  end

  // Round FSM next state, scoring, countdown and mole lifetime.
  always_comb begin
    state_d    = state_q;
    mole_d     = mole_q;
    secs_d     = secs_q;
    score_d    = score_q;
    mtmr_d     = mtmr_q;
    enter_play = 1'b0;
    hit_ok     = |(hit_i & mole_q);
    unique case (state_q)
      ST_IDLE, ST_OVER: begin
        if (start_i) begin
          state_d    = ST_PLAY;
          secs_d     = SECS_INIT;
          score_d    = '0;
          mtmr_d     = '0;
          mole_d     = place;
          enter_play = 1'b1;
        end
      end
      ST_PLAY: begin
        if (hit_ok && (score_q != '1)) begin
          score_d = score_q + SCORE_W'(1);
        end
        // The final tick ends the round; a hit on that edge has already been scored above.
        if (tick && (secs_q == SECS_W'(1))) begin
          state_d = ST_OVER;
          secs_d  = '0;
          mole_d  = '0;
          mtmr_d  = '0;
        end else begin
          if (tick) begin
            secs_d = secs_q - SECS_W'(1);
          end
          if (hit_ok || (mtmr_q == MT_LAST)) begin
            mole_d = reloc;
            mtmr_d = '0;
          end else begin
            mtmr_d = mtmr_q + MT_W'(1);
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Game state registers; the LFSR free-runs in every state.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q <= ST_IDLE;
      lfsr_q  <= LFSR_SEED;
      mole_q  <= '0;
      secs_q  <= SECS_INIT;
      score_q <= '0;
      mtmr_q  <= '0;
    end else begin
      state_q <= state_d;
      lfsr_q  <= lfsr_step(lfsr_q);
      mole_q  <= mole_d;
      secs_q  <= secs_d;
      score_q <= score_d;
      mtmr_q  <= mtmr_d;
    end
  end

  whack_tick_gen #(
    .TICK_DIV (TICK_DIV)
  ) u_tick (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .clr_i   (enter_play),
    .en_i    (state_d == ST_PLAY),
    .tick_o  (tick)
  );

`ifdef WHACK_BEST_SCORE_EN
  logic [SCORE_W-1:0] best_q, best_d;

  // High score captured on the PLAY->OVER edge, using the score including that edge's hit.
  always_comb begin
    best_d = best_q;
    if ((state_q == ST_PLAY) && (state_d == ST_OVER) && (score_d > best_q)) begin
      best_d = score_d;
    end
  end

  // High score register, cleared only by reset.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      best_q <= '0;
    end else begin
      best_q <= best_d;
    end
  end

  assign best_o = best_q;
`endif

  assign mole_o     = mole_q;
  assign secs_o     = secs_q;
  assign score_o    = score_q;
  assign state_o    = state_q;
  assign sec_tick_o = tick;

endmodule
